instr_stream_driver: RTL and testbench

// Parametrised instruction sequencer that feeds the processor core's instruction input and captures its store traffic.
// A program is loaded into a local buffer, then issued one word at a time in run, single-step or loop mode.
// NOP gaps between issued words are programmable.

---
 rtl/instr_stream_driver.sv | 171 +++++++++++++++++
 tb/tb_instr_stream_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_driver.sv
// Instruction sequencer: loads a program buffer, issues words to the core in
// run, single-step or loop mode, and captures core store traffic in a trace FIFO.
module instr_stream_driver #(
   parameter int IW          = 32,
   parameter int DEPTH       = 16,
   parameter int AW          = 8,
   parameter int DW          = 32,
   parameter int GAP         = 1,
   parameter int TRACE_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_valid,
   input  logic [IW-1:0]            load_data,
   input  logic                     load_clear,
   input  logic [1:0]               mode,
   input  logic                     start,
   input  logic                     step,
   input  logic                     abort,
   output logic [IW-1:0]            instruction,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH)-1:0] pc_out,
   output logic                     busy,
   output logic                     done,
   output logic                     load_err,
   input  logic                     proc_wr,
   input  logic [AW-1:0]            proc_addr,
   input  logic [DW-1:0]            proc_wdata,
   input  logic                     trace_rd,
   output logic [AW+DW-1:0]         trace_data,
   output logic                     trace_empty,
   output logic                     trace_full,
   output logic                     trace_ovf
);

   localparam int PW  = $clog2(DEPTH);
   localparam int LW  = PW + 1;
   localparam int GW  = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int TPW = $clog2(TRACE_DEPTH);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [2:0] {IDLE, ISSUE, GAP_WAIT, WAIT_STEP, DONE} state_t;

   state_t        state;
   logic [IW-1:0] buffer [DEPTH];
   logic [LW-1:0] prog_len;
   logic [PW-1:0] pc;
   logic [1:0]    run_mode;
   logic [GW-1:0] gap_cnt;

   logic   start_ok, load_we, last;
   state_t succ_state;
   logic [PW-1:0] succ_pc;

   assign start_ok = start && ((state == IDLE && prog_len != '0) || (state == DONE && !abort));
   assign load_we  = !rst && state == IDLE && !start_ok && !load_clear && load_valid
                     && prog_len != LW'(DEPTH);
   assign last     = ({1'b0, pc} == prog_len - LW'(1));

   // Where the sequencer goes once the current word (and its gap) is finished.
   always_comb begin
      succ_state = DONE;
      succ_pc    = pc;
      if (!last) begin
         succ_pc    = pc + PW'(1);
         succ_state = (run_mode == 2'b01) ? WAIT_STEP : ISSUE;
      end else if (run_mode == 2'b10) begin
         succ_pc    = '0;
         succ_state = ISSUE;
      end
   end

   always_ff @(posedge clk) begin
      if (load_we) buffer[prog_len[PW-1:0]] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         instruction <= '0;
         issue_valid <= 1'b0;
         pc_out      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         load_err    <= 1'b0;
         prog_len    <= '0;
         pc          <= '0;
         run_mode    <= 2'b00;
         gap_cnt     <= '0;
      end else begin
         instruction <= '0;
         issue_valid <= 1'b0;
         if (state != IDLE && abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else if (start_ok) begin
            // Reserved mode 11 behaves as run-once.
            state    <= ISSUE;
            pc       <= '0;
            run_mode <= (mode == 2'b11) ? 2'b00 : mode;
            busy     <= 1'b1;
            done     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (load_clear) prog_len <= '0;
                  else if (load_valid) begin
                     if (prog_len == LW'(DEPTH)) load_err <= 1'b1;
                     else prog_len <= prog_len + LW'(1);
                  end
               end
               ISSUE: begin
                  instruction <= buffer[pc];
                  issue_valid <= 1'b1;
                  pc_out      <= pc;
                  if (GAP > 0) begin
                     state   <= GAP_WAIT;
                     gap_cnt <= GAP_LAST;
                  end else begin
                     state <= succ_state;
                     pc    <= succ_pc;
                     busy  <= (succ_state != DONE);
                     done  <= (succ_state == DONE);
                  end
               end
               GAP_WAIT: begin
                  if (gap_cnt == '0) begin
                     state <= succ_state;
                     pc    <= succ_pc;
                     busy  <= (succ_state != DONE);
                     done  <= (succ_state == DONE);
                  end else begin
                     gap_cnt <= gap_cnt - GW'(1);
                  end
               end
               WAIT_STEP: if (step) state <= ISSUE;
               default: ;
            endcase
         end
      end
   end

   // Trace FIFO with an extra pointer bit to tell full from empty.
   logic [AW+DW-1:0] tmem [TRACE_DEPTH];
   logic [TPW:0]     wp, rp;
   logic             pop, push;

   assign trace_empty = (wp == rp);
   assign trace_full  = (wp[TPW] != rp[TPW]) && (wp[TPW-1:0] == rp[TPW-1:0]);
   assign trace_data  = tmem[rp[TPW-1:0]];
   assign pop         = trace_rd && !trace_empty;
   assign push        = proc_wr && (!trace_full || pop);

   always_ff @(posedge clk) begin
      if (push) tmem[wp[TPW-1:0]] <= {proc_addr, proc_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         wp        <= '0;
         rp        <= '0;
         trace_ovf <= 1'b0;
      end else begin
         if (push) wp <= wp + (TPW+1)'(1);
         if (pop)  rp <= rp + (TPW+1)'(1);
         if (proc_wr && !push) trace_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_stream_driver.sv
// Randomized bench for instr_stream_driver against a cycle-position model of
// issue timing and a queue model of the trace FIFO.
module tb_instr_stream_driver;
   localparam int IW = 32, DEPTH = 16, AW = 8, DW = 32, G = 1, TD = 8;

   logic clk = 0, rst = 1;
   logic load_valid = 0, load_clear = 0, start = 0, step = 0, abort = 0;
   logic [IW-1:0] load_data = '0;
   logic [1:0] mode = 2'b00;
   logic [IW-1:0] instruction;
   logic issue_valid, busy, done, load_err;
   logic [$clog2(DEPTH)-1:0] pc_out;
   logic proc_wr = 0, trace_rd = 0;
   logic [AW-1:0] proc_addr = '0;
   logic [DW-1:0] proc_wdata = '0;
   logic [AW+DW-1:0] trace_data;
   logic trace_empty, trace_full, trace_ovf;

   always #5 clk = ~clk;

   instr_stream_driver #(.IW(IW), .DEPTH(DEPTH), .AW(AW), .DW(DW), .GAP(G), .TRACE_DEPTH(TD)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_clear(load_clear),
      .mode(mode), .start(start), .step(step), .abort(abort), .instruction(instruction),
      .issue_valid(issue_valid), .pc_out(pc_out), .busy(busy), .done(done), .load_err(load_err),
      .proc_wr(proc_wr), .proc_addr(proc_addr), .proc_wdata(proc_wdata), .trace_rd(trace_rd),
      .trace_data(trace_data), .trace_empty(trace_empty), .trace_full(trace_full), .trace_ovf(trace_ovf));

   int checks = 0, errors = 0;
   logic [IW-1:0] prog [0:DEPTH];
   logic [AW+DW-1:0] q[$];
   logic m_ovf = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_prog(input int n);
      load_clear = 1; tick(); load_clear = 0;
      for (int i = 0; i < n; i++) begin
         load_valid = 1; load_data = prog[i]; tick();
      end
      load_valid = 0;
   endtask

   task automatic set_t1();
      prog[0] = 32'he3a00007; prog[1] = 32'he3a01002; prog[2] = 32'he3a02003;
      prog[3] = 32'he0813002; prog[4] = 32'he1500003;
   endtask

   // Word k appears (G+1)*k+1 cycles after the start edge; run ends at L*(G+1).
   task automatic run_check(input string tag, input int L, input logic [1:0] md,
                            input int cycles, output int issued);
      int k; bit onw, loopm; logic [IW-1:0] ei;
      issued = 0; loopm = (md == 2'b10);
      mode = md; start = 1; tick(); start = 0;
      for (int c = 0; c < cycles; c++) begin
         onw = (c >= 1) && ((c - 1) % (G + 1) == 0);
         k = (c >= 1) ? (c - 1) / (G + 1) : 0;
         if (onw && !loopm && k >= L) onw = 0;
         ei = '0;
         if (onw) ei = prog[k % L];
         chk({tag, "_instr"}, 64'(instruction), 64'(ei));
         chk({tag, "_valid"}, 64'(issue_valid), 64'(onw));
         if (onw) chk({tag, "_pc"}, 64'(pc_out), 64'(k % L));
         chk({tag, "_busy"}, 64'(busy), 64'(loopm ? 1'b1 : (c < L * (G + 1))));
         chk({tag, "_done"}, 64'(done), 64'(loopm ? 1'b0 : (c >= L * (G + 1))));
         if (issue_valid) issued++;
         tick();
      end
   endtask

   task automatic abort_check(input string tag);
      abort = 1; tick(); abort = 0;
      chk({tag, "_instr"}, 64'(instruction), 64'(0));
      chk({tag, "_valid"}, 64'(issue_valid), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
   endtask

   task automatic fifo_check(input string tag);
      chk({tag, "_empty"}, 64'(trace_empty), 64'(q.size() == 0));
      chk({tag, "_full"}, 64'(trace_full), 64'(q.size() == TD));
      chk({tag, "_ovf"}, 64'(trace_ovf), 64'(m_ovf));
      if (q.size() > 0) chk({tag, "_data"}, 64'(trace_data), 64'(q[0]));
   endtask

   task automatic fifo_cycle(input bit wr, input bit rd);
      logic [AW+DW-1:0] e; bit popd;
      e = {8'($urandom), 32'($urandom)};
      proc_wr = wr; proc_addr = e[AW+DW-1:DW]; proc_wdata = e[DW-1:0]; trace_rd = rd;
      popd = rd && (q.size() > 0);
      if (popd) void'(q.pop_front());
      if (wr) begin
         if (q.size() < TD) q.push_back(e);
         else m_ovf = 1;
      end
      tick(); proc_wr = 0; trace_rd = 0;
      fifo_check("fifo");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, r;
      logic [1:0] md;
      rst = 1; tick(); tick();
      chk("rst_instr", 64'(instruction), 64'(0));
      chk("rst_valid", 64'(issue_valid), 64'(0));
      chk("rst_pc", 64'(pc_out), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_lerr", 64'(load_err), 64'(0));
      chk("rst_empty", 64'(trace_empty), 64'(1));
      chk("rst_full", 64'(trace_full), 64'(0));
      chk("rst_ovf", 64'(trace_ovf), 64'(0));
      rst = 0;

      // T1: run-once, then restart from DONE using the reserved mode
      set_t1(); load_prog(5);
      run_check("t1", 5, 2'b00, 14, n); chk("t1_issues", 64'(n), 64'(5));
      run_check("t1r", 5, 2'b11, 14, n); chk("t1r_issues", 64'(n), 64'(5));
      abort_check("t1_abort");

      // T2: loop wraps to word 0, abort stops it
      run_check("t2", 5, 2'b10, 25, n);
      abort_check("t2_abort");

      // T3: single-step, including steps that land in the gap or after done
      mode = 2'b01; start = 1; tick(); start = 0;
      chk("t3_c0", 64'(instruction), 64'(0));
      tick();
      for (int w = 0; w < 5; w++) begin
         chk("t3_word", 64'(instruction), 64'(prog[w]));
         chk("t3_valid", 64'(issue_valid), 64'(1));
         step = 1; tick(); step = 0;
         if (w < 4) begin
            chk("t3_gapstep", 64'(instruction), 64'(0));
            r = $urandom_range(1, 4);
            repeat (r) begin
               chk("t3_wait_instr", 64'(instruction), 64'(0));
               chk("t3_wait_busy", 64'(busy), 64'(1));
               chk("t3_wait_done", 64'(done), 64'(0));
               tick();
            end
            step = 1; tick(); step = 0;
            chk("t3_stepedge", 64'(instruction), 64'(0));
            tick();
         end
      end
      chk("t3_done", 64'(done), 64'(1));
      chk("t3_busy", 64'(busy), 64'(0));
      step = 1; tick(); step = 0;
      chk("t3_extra_instr", 64'(instruction), 64'(0));
      chk("t3_extra_valid", 64'(issue_valid), 64'(0));
      chk("t3_extra_done", 64'(done), 64'(1));
      abort_check("t3_abort");

      // T4: overfill the buffer, then start with an empty program
      for (int i = 0; i <= DEPTH; i++) prog[i] = $urandom;
      load_prog(DEPTH);
      chk("t4_lerr_pre", 64'(load_err), 64'(0));
      load_valid = 1; load_data = prog[DEPTH]; tick(); load_valid = 0;
      chk("t4_lerr", 64'(load_err), 64'(1));
      run_check("t4", DEPTH, 2'b00, DEPTH * (G + 1) + 3, n);
      chk("t4_issues", 64'(n), 64'(DEPTH));
      abort_check("t4_abort");
      load_clear = 1; tick(); load_clear = 0;
      mode = 2'b00; start = 1; tick(); start = 0;
      repeat (6) begin
         chk("t4_empty_valid", 64'(issue_valid), 64'(0));
         chk("t4_empty_busy", 64'(busy), 64'(0));
         tick();
      end

      // Random programs and modes
      repeat (5) begin
         r = $urandom_range(1, DEPTH);
         for (int i = 0; i < r; i++) prog[i] = $urandom;
         case ($urandom_range(0, 2)) 0: md = 2'b00; 1: md = 2'b10; default: md = 2'b11; endcase
         load_prog(r);
         run_check("rnd", r, md, (md == 2'b10) ? 2 * r * (G + 1) + 3 : r * (G + 1) + 3, n);
         if (md != 2'b10) chk("rnd_issues", 64'(n), 64'(r));
         abort_check("rnd_abort");
      end

      // T5: trace FIFO overflow, push+pop at full, ordered drain, random traffic
      repeat (9) fifo_cycle(1, 0);
      chk("t5_full", 64'(trace_full), 64'(1));
      chk("t5_ovf", 64'(trace_ovf), 64'(1));
      fifo_cycle(1, 1);
      chk("t5_full_pp", 64'(trace_full), 64'(1));
      repeat (8) fifo_cycle(0, 1);
      chk("t5_drained", 64'(trace_empty), 64'(1));
      fifo_cycle(0, 1);
      repeat (300) fifo_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
      set_t1(); load_prog(5);
      repeat (3) fifo_cycle(1, 0);
      mode = 2'b00; start = 1; proc_wr = 1; tick(); start = 0; proc_wr = 0;
      q.delete(); m_ovf = 0;
      fifo_check("t5_start");
      abort_check("t5_abort");

      // T6: reset while word 2 is in ISSUE
      mode = 2'b00; start = 1; tick(); start = 0;
      tick(); tick();
      proc_wr = 1; tick(); proc_wr = 0;
      tick();
      chk("t6_pushed", 64'(trace_empty), 64'(0));
      rst = 1; tick();
      chk("t6_instr", 64'(instruction), 64'(0));
      chk("t6_valid", 64'(issue_valid), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      chk("t6_done", 64'(done), 64'(0));
      chk("t6_pc", 64'(pc_out), 64'(0));
      chk("t6_empty", 64'(trace_empty), 64'(1));
      chk("t6_lerr", 64'(load_err), 64'(0));
      rst = 0; q.delete(); m_ovf = 0;
      load_prog(5);
      run_check("t6", 5, 2'b00, 14, n);
      chk("t6_issues", 64'(n), 64'(5));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
